// File: rtl/adc_oversample_avg.sv
// Per-channel oversampling averager: sums 2^LOG2_SAMPLES samples per channel and publishes the mean.
// Define ADC_OVERSAMPLE_ROUND_EN for round-half-up averaging; otherwise the average is truncated.
module adc_oversample_avg #(
  parameter int CHANNELS     = 8,
  parameter int LOG2_SAMPLES = 4,
  parameter int DATA_W       = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [4:0]             in_channel,
  input  logic [DATA_W-1:0]      in_data,
  output logic [CHANNELS*16-1:0] avg_flat,
  output logic [CHANNELS-1:0]    avg_ready,
  output logic                   upd_valid,
  output logic [4:0]             upd_channel,
  output logic [7:0]             drop_count
);

  // Handshake: in_valid qualifies in_channel/in_data for one cycle and is always consumed
  // (no ready); upd_valid is a one-cycle strobe qualifying upd_channel, with no backpressure.

  localparam int ACC_W = DATA_W + LOG2_SAMPLES;
`ifdef ADC_OVERSAMPLE_ROUND_EN
  localparam logic [ACC_W-1:0] ROUND_BIAS = ACC_W'(1) << (LOG2_SAMPLES - 1);
`else
  localparam logic [ACC_W-1:0] ROUND_BIAS = '0;
`endif

  logic [ACC_W-1:0]        acc [CHANNELS];
  logic [LOG2_SAMPLES-1:0] cnt [CHANNELS];

  logic [CHANNELS-1:0]     hit;
  logic                    accepted;
  logic [ACC_W-1:0]        sel_acc;
  logic [LOG2_SAMPLES-1:0] sel_cnt;
  logic [ACC_W-1:0]        sum;
  logic [ACC_W-1:0]        sum_r;
  logic [15:0]             avg16;
  logic                    is_final;

  // Only one sample arrives per cycle, so a single shared adder serves all channels.
  always_comb begin
    hit     = '0;
    sel_acc = '0;
    sel_cnt = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (in_valid && (in_channel == 5'(c + 1))) begin
        hit[c]  = 1'b1;
        sel_acc = acc[c];
        sel_cnt = cnt[c];
      end
    end
    accepted = |hit;
    sum      = sel_acc + ACC_W'(in_data);
    sum_r    = sum + ROUND_BIAS;
    avg16    = 16'(sum_r >> LOG2_SAMPLES);
    is_final = (sel_cnt == '1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        acc[c] <= '0;
        cnt[c] <= '0;
      end
      avg_flat    <= '0;
      avg_ready   <= '0;
      upd_valid   <= 1'b0;
      upd_channel <= '0;
      drop_count  <= '0;
    end else begin
      upd_valid <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        if (hit[c]) begin
          if (is_final) begin
            acc[c]               <= '0;
            cnt[c]               <= '0;
            avg_flat[c*16 +: 16] <= avg16;
            avg_ready[c]         <= 1'b1;
          end else begin
            acc[c] <= sum;
            cnt[c] <= sel_cnt + LOG2_SAMPLES'(1);
          end
        end
      end
      if (accepted && is_final) begin
        upd_valid   <= 1'b1;
        upd_channel <= in_channel;
      end
      if (in_valid && !accepted && (drop_count != 8'hFF))
        drop_count <= drop_count + 8'd1;
    end
  end

endmodule
